// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max-pool stage for one row-major feature map.
// Even-column pixels are parked in pair_max. Odd-column pixels close a
// horizontal pair. On even rows the pair maximum is stored in the line
// buffer. On odd rows it is compared with the stored top-row maximum to
// produce one pooled output.
// Optional build macro MAXPOOL_ARGMAX_EN adds out_idx, the position of the
// maximum inside the window: 0=TL, 1=TR, 2=BL, 3=BR. Ties go to the lowest index.
module max_pool_2x2 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     valid_in,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     valid_out,
    output logic                     frame_done
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [1:0]               out_idx
`endif
);

    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
    localparam int LB_N  = 1 << LB_AW;
    localparam int COL_W = LB_AW + 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
`ifdef MAXPOOL_ARGMAX_EN
    localparam int LB_W  = DATA_W + 1;   // extra bit: top-row winner was the right pixel
`else
    localparam int LB_W  = DATA_W;
`endif

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_cfg
        $error("max_pool_2x2: IMG_W and IMG_H must be even and at least 2");
    end

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] pair_max_q, pair_max_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     valid_out_q, valid_out_d;
    logic                     frame_done_q, frame_done_d;
`ifdef MAXPOOL_ARGMAX_EN
    logic [1:0]               out_idx_q, out_idx_d;
`endif

    logic [LB_W-1:0]          lb_q [LB_N];
    logic [LB_AW-1:0]         lb_idx;
    logic [LB_W-1:0]          lb_rd, lb_wr;
    logic                     lb_we;
    logic signed [DATA_W-1:0] top_max, pair_m, win_m;
    logic                     pair_keep, win_keep, col_last, row_last;

    // Next-state: counters, pair/window maxima, output registers.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_max_d   = pair_max_q;
        out_data_d   = out_data_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        lb_idx       = col_q[LB_AW:1];
        lb_rd        = lb_q[lb_idx];
        top_max      = lb_rd[DATA_W-1:0];
        col_last     = (col_q == COL_W'(IMG_W - 1));
        row_last     = (row_q == ROW_W'(IMG_H - 1));
        // Ties keep the earlier (lower-index) candidate.
        pair_keep    = (pair_max_q >= in_data);
        pair_m       = pair_keep ? pair_max_q : in_data;
        win_keep     = (top_max >= pair_m);
        win_m        = win_keep ? top_max : pair_m;
`ifdef MAXPOOL_ARGMAX_EN
        lb_wr        = {~pair_keep, pair_m};
        out_idx_d    = out_idx_q;
`else
        lb_wr        = pair_m;
`endif
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                pair_max_d = in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_data_d   = win_m;
                valid_out_d  = 1'b1;
                frame_done_d = row_last && col_last;
`ifdef MAXPOOL_ARGMAX_EN
                out_idx_d    = win_keep ? {1'b0, lb_rd[DATA_W]} : {1'b1, ~pair_keep};
`endif
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_max_q   <= '0;
            out_data_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
            out_idx_q    <= 2'd0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_max_q   <= pair_max_d;
            out_data_q   <= out_data_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
`ifdef MAXPOOL_ARGMAX_EN
            out_idx_q    <= out_idx_d;
`endif
        end
    end

    // Line buffer of top-row pair maxima; every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= lb_wr;
        end
    end

    assign out_data   = out_data_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
`ifdef MAXPOOL_ARGMAX_EN
    assign out_idx    = out_idx_q;
`endif

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2 at 4x4. Expected pooled values come from a direct
// max-of-four over each window of a stored frame image.
module tb_max_pool_2x2;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] in_data;
    logic                 valid_in;
    logic signed [DW-1:0] out_data;
    logic                 valid_out;
    logic                 frame_done;
`ifdef MAXPOOL_ARGMAX_EN
    logic [1:0]           out_idx;
`endif

    int n_vec = 0;
    int n_err = 0;
    int pix [H][W];
    int last_out;

    max_pool_2x2 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .valid_in   (valid_in),
        .out_data   (out_data),
        .valid_out  (valid_out),
        .frame_done (frame_done)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .out_idx    (out_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            @(posedge clk);
            #1;
            check("bubble_valid_out", valid_out, 0);
            check("bubble_frame_done", frame_done, 0);
            check("bubble_out_hold", out_data, last_out);
        end
    endtask

    // Drive pix[][] row-major, optionally with random 0-3 cycle bubbles before each pixel.
    task automatic drive_frame(input bit bub);
        int eq[$];
        int iq[$];
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                int best;
                int bi;
                best = pix[2*wr][2*wc];
                bi   = 0;
                for (int k = 1; k < 4; k++) begin
                    int v;
                    v = pix[2*wr + k/2][2*wc + k%2];
                    if (v > best) begin
                        best = v;
                        bi   = k;
                    end
                end
                eq.push_back(best);
                iq.push_back(bi);
            end
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                bit exp_v;
                if (bub) bubble(int'($urandom_range(0, 3)));
                @(negedge clk);
                valid_in = 1'b1;
                in_data  = DW'(pix[r][c]);
                @(posedge clk);
                #1;
                exp_v = (r % 2 == 1) && (c % 2 == 1);
                check("valid_out", valid_out, exp_v);
                check("frame_done", frame_done, exp_v && r == H - 1 && c == W - 1);
                if (exp_v) begin
                    last_out = eq.pop_front();
`ifdef MAXPOOL_ARGMAX_EN
                    check("out_idx", out_idx, iq.pop_front());
`endif
                end
                check("out_data", out_data, last_out);
            end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        in_data  = '0;
        last_out = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_frame_done", frame_done, 0);
`ifdef MAXPOOL_ARGMAX_EN
        check("rst_out_idx", out_idx, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, continuous valid: 5, 7, 13, 15.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = r * 4 + c;
        drive_frame(1'b0);

        // Same ramp with random bubbles.
        drive_frame(1'b1);
        bubble(2);

        // Signed frame: -3 everywhere, -1 at (1,2): -3, -1, -3, -3.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = -3;
        pix[1][2] = -1;
        drive_frame(1'b0);

        // Two back-to-back frames: ramp, then ramp+100.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = r * 4 + c;
        drive_frame(1'b0);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = r * 4 + c + 100;
        drive_frame(1'b0);

        // Reset mid-frame after 6 pixels; the pixel-5 pulse is live when reset hits.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            in_data  = DW'(i + 50);
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_frame_done", frame_done, 0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        last_out = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = r * 4 + c;
        drive_frame(1'b0);

        // All-equal frame: value 9, ties pick top-left.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 9;
        drive_frame(1'b0);

        // Unique max at bottom-left of every window.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
            pix[r][c] = ((r % 2 == 1) && (c % 2 == 0)) ? 7 : 0;
        drive_frame(1'b1);

        // Random full-range signed frames with bubbles.
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
                pix[r][c] = int'($urandom_range(0, 65535)) - 32768;
            drive_frame(1'b1);
        end

        // Random small-range frames, dense in ties.
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
                pix[r][c] = int'($urandom_range(0, 2)) - 1;
            drive_frame(f[0]);
        end
        bubble(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage.
- Sits directly downstream of the ReLU activation stage. Consumes its out_data/valid_out stream (row-major pixels of one feature map) and emits one pooled value per 2x2 window.
- Valid-only streaming: no backpressure. Holds one line of partial maxima internally.

Parameters:
- DATA_W, 16, signed pixel width in and out.
- IMG_W, 28, input feature-map width in pixels; must be even.
- IMG_H, 28, input feature-map height in pixels; must be even.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  signed activated pixel, row-major order.
- valid_in  input  1  in_data valid this cycle; one pixel accepted per high cycle.
- out_data  output  DATA_W  signed pooled maximum.
- valid_out  output  1  out_data valid; single-cycle pulse per window.
- frame_done  output  1  pulses together with the last pooled output of a frame.

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - out_data=0, valid_out=0, frame_done=0.
  - col=0, row=0, pair_max=0.
  - Line buffer contents are not reset; every entry is written on an even row before it is read.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1.
  - Both advance only on cycles with valid_in=1.
  - col wraps to 0 and increments row. After (IMG_H-1, IMG_W-1), both wrap to 0, so the next pixel starts a new frame.
- valid_in=0 cycles: no state change; valid_out=0 and frame_done=0 on the next edge. Arbitrary bubbles are allowed anywhere in the stream.
- Per accepted pixel:
  - col even: pair_max <= in_data.
  - col odd: m = max(pair_max, in_data), with the tie keeping pair_max.
    - row even: line_buf[col>>1] <= m.
    - row odd: out_data <= max(line_buf[col>>1], m), with the tie keeping line_buf; valid_out <= 1.
- All comparisons are signed, full DATA_W. No width growth and no saturation.
- Latency: valid_out rises on the clock edge that accepts the bottom-right pixel of a window; out_data is visible in the following cycle.
  - Outputs per frame: (IMG_W/2)*(IMG_H/2), in row-major pooled order.
- frame_done = 1 in the same cycle as valid_out for window (IMG_H/2-1, IMG_W/2-1); 0 otherwise.
- out_data holds its last value while valid_out=0.
- Line buffer: IMG_W/2 entries x DATA_W. Register array or inferred distributed RAM, one read and one write per cycle. Read and write never target the same entry in the same cycle.
- Reset mid-frame discards the partial frame and any pending window. The first valid pixel after release is pixel (0,0).
- Odd IMG_W or IMG_H is a configuration error: an elaboration-time assertion/$error.

Optional Feature:
- Macro MAXPOOL_ARGMAX_EN.
- Defined:
  - Adds output port out_idx [1:0], valid with valid_out, giving the window position of the max: 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
  - Ties resolve to the lowest index.
  - Line buffer widens by 1 bit to store the top-row winner's column bit.
  - out_idx resets to 0.
- Not defined: the port and the extra storage are absent; all other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=4, continuous valid_in, pixel value = row*4+col:
  - exactly 4 valid_out pulses, out_data 5, 7, 13, 15;
  - each pulse one cycle after pixels 5, 7, 13, 15 are accepted;
  - frame_done only with 15.
- Same frame with random 0-3 cycle bubbles between pixels -> identical output values and order; valid_out never asserted during bubbles except as the one-cycle-delayed pulse.
- Signed check, 4x4, all pixels -3 except pixel (1,2) = -1 -> outputs -3, -1, -3, -3.
- Two back-to-back 4x4 frames (first ramp, second ramp+100) -> 8 outputs (5, 7, 13, 15, 105, 107, 113, 115), frame_done twice.
- Reset mid-frame: drive 6 pixels, pulse rst_n low asynchronously (mid-cycle), then a full ramp frame -> outputs exactly 5, 7, 13, 15. Also check valid_out=0 and out_data=0 immediately while rst_n is low.
- With MAXPOOL_ARGMAX_EN:
  - all pixels 9 -> out_idx=0 on every window;
  - ramp frame -> out_idx=3 on every window;
  - window with unique max at bottom-left -> out_idx=2.
